// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: bundles the CPU-side request/response handshake and the
// word-wide data-memory port of the load/store unit.
//   req_*   : byte-addressed request (valid/ready), driven by the CPU side
//   resp_*  : one-cycle response pulse with load data / alignment error
//   mem_*   : word address, write data, read/write strobes, read data
// Modports:
//   master : CPU + memory environment (drives req_*, mem_outData)
//   slave  : the load/store unit itself
interface mem_access_unit_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_error;

  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_inData;
  logic              mem_memRead;
  logic              mem_memWrite;
  logic [31:0]       mem_outData;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_outData,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_inData, mem_memRead, mem_memWrite
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_outData,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_inData, mem_memRead, mem_memWrite
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store controller between the CPU memory stage and a
// 2^ADDR_W x 32-bit synchronous data memory.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any transaction in flight)
//   bus   : mem_access_unit_if.slave
//             req_*  byte/half/word requests, accepted only in IDLE
//             resp_* one-cycle response (load data or alignment error)
//             mem_*  registered word address/data and read/write strobes
// Sub-word stores are read-modify-write (RD -> MERGE -> WR); loads read the
// word, then extract and extend the addressed lane(s) (RD -> CAP).
module mem_access_unit #(
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_access_unit_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    CAP   = 3'd2,
    MERGE = 3'd3,
    WR    = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t            state;

  // Request fields still needed after the accept edge.
  logic              write_reg;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic [1:0]        lane_reg;
  logic [15:0]       wdata_reg;

  // Registered outputs.
  logic              req_ready_reg;
  logic              resp_valid_reg;
  logic [31:0]       resp_rdata_reg;
  logic              resp_error_reg;
  logic [ADDR_W-1:0] mem_address_reg;
  logic [31:0]       mem_in_data_reg;
  logic              mem_read_reg;
  logic              mem_write_reg;

  assign bus.req_ready    = req_ready_reg;
  assign bus.resp_valid   = resp_valid_reg;
  assign bus.resp_rdata   = resp_rdata_reg;
  assign bus.resp_error   = resp_error_reg;
  assign bus.mem_address  = mem_address_reg;
  assign bus.mem_inData   = mem_in_data_reg;
  assign bus.mem_memRead  = mem_read_reg;
  assign bus.mem_memWrite = mem_write_reg;

  // Misaligned halfword/word or the reserved size code.
  logic req_bad;
  always_comb begin
    req_bad = 1'b0;
    unique case (bus.req_size)
      2'd0:    req_bad = 1'b0;
      2'd1:    req_bad = bus.req_addr[0];
      2'd2:    req_bad = (bus.req_addr[1:0] != 2'd0);
      default: req_bad = 1'b1;
    endcase
  end

  // Load extraction: pick the addressed lane(s) and extend.
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_value;
  always_comb begin
    lane_byte = 8'h00;
    unique case (lane_reg)
      2'd0: lane_byte = bus.mem_outData[7:0];
      2'd1: lane_byte = bus.mem_outData[15:8];
      2'd2: lane_byte = bus.mem_outData[23:16];
      2'd3: lane_byte = bus.mem_outData[31:24];
    endcase
    lane_half  = lane_reg[1] ? bus.mem_outData[31:16] : bus.mem_outData[15:0];
    load_value = bus.mem_outData;
    unique case (size_reg)
      2'd0:    load_value = {{24{signed_reg & lane_byte[7]}}, lane_byte};
      2'd1:    load_value = {{16{signed_reg & lane_half[15]}}, lane_half};
      default: load_value = bus.mem_outData;
    endcase
  end

  // Store merge: each byte lane either keeps the word read back from memory
  // or takes a byte of the store data. A halfword store feeds wdata[7:0] to
  // the even lane and wdata[15:8] to the odd lane of the selected half.
  logic [31:0] merged;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       hit;
      logic [7:0] src;
      assign hit = (size_reg == 2'd0) ? (lane_reg == 2'(gi))
                                      : (lane_reg[1] == ((gi >= 2) ? 1'b1 : 1'b0));
      assign src = (size_reg == 2'd0) ? wdata_reg[7:0] : wdata_reg[8*(gi%2) +: 8];
      assign merged[8*gi +: 8] = hit ? src : bus.mem_outData[8*gi +: 8];
    end
  endgenerate

  // Single-process FSM; every output is a register. Strobes are set on the
  // edge that enters RD/WR so they are high for exactly that state's cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      write_reg       <= 1'b0;
      size_reg        <= 2'd0;
      signed_reg      <= 1'b0;
      lane_reg        <= 2'd0;
      wdata_reg       <= 16'h0000;
      req_ready_reg   <= 1'b1;
      resp_valid_reg  <= 1'b0;
      resp_rdata_reg  <= 32'h0;
      resp_error_reg  <= 1'b0;
      mem_address_reg <= '0;
      mem_in_data_reg <= 32'h0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
    end else begin
      resp_valid_reg <= 1'b0;
      resp_error_reg <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_reg     <= bus.req_write;
            size_reg      <= bus.req_size;
            signed_reg    <= bus.req_signed;
            lane_reg      <= bus.req_addr[1:0];
            wdata_reg     <= bus.req_wdata[15:0];
            req_ready_reg <= 1'b0;
            if (req_bad) begin
              state <= ERR;
            end else if (bus.req_write && bus.req_size == 2'd2) begin
              state           <= WR;
              mem_address_reg <= bus.req_addr[ADDR_W+1:2];
              mem_in_data_reg <= bus.req_wdata;
              mem_write_reg   <= 1'b1;
            end else begin
              state           <= RD;
              mem_address_reg <= bus.req_addr[ADDR_W+1:2];
              mem_read_reg    <= 1'b1;
            end
          end
        end
        RD: begin
          // Read data appears during the next state's cycle.
          state <= write_reg ? MERGE : CAP;
        end
        CAP: begin
          state          <= IDLE;
          req_ready_reg  <= 1'b1;
          resp_valid_reg <= 1'b1;
          resp_rdata_reg <= load_value;
        end
        MERGE: begin
          state           <= WR;
          mem_in_data_reg <= merged;
          mem_write_reg   <= 1'b1;
        end
        WR: begin
          state          <= IDLE;
          req_ready_reg  <= 1'b1;
          resp_valid_reg <= 1'b1;
          resp_rdata_reg <= 32'h0;
        end
        ERR: begin
          state          <= IDLE;
          req_ready_reg  <= 1'b1;
          resp_valid_reg <= 1'b1;
          resp_error_reg <= 1'b1;
          resp_rdata_reg <= 32'h0;
        end
        default: begin
          state         <= IDLE;
          req_ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed + randomized bench for mem_access_unit.
// The data memory is modelled as a word array with one-cycle read latency;
// expected results come from a byte-addressed reference memory.
module tb_mem_access_unit;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Environment memory: samples strobes at the edge ending the strobe cycle.
  logic [31:0] mem_array [0:255];
  always @(posedge clk) begin
    if (bus.mem_memWrite === 1'b1) mem_array[bus.mem_address] <= bus.mem_inData;
    if (bus.mem_memRead === 1'b1)  bus.mem_outData <= mem_array[bus.mem_address];
  end

  // Reference model: plain byte-addressed memory.
  logic [7:0] ref_bytes [0:1023];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_bad(input logic [1:0] sz, input logic [9:0] a);
    int unsigned ai;
    ai = a;
    return (sz == 2'd3) || (sz == 2'd1 && (ai % 2) != 0) || (sz == 2'd2 && (ai % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned byte_addr);
    longint v;
    int unsigned base;
    v = 0;
    base = byte_addr - (byte_addr % 4);
    for (int i = 0; i < 4; i++) v += longint'(ref_bytes[base + i]) << (8 * i);
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_load(input logic [9:0] a, input logic [1:0] sz, input logic sg);
    longint v;
    int n;
    v = 0;
    n = nbytes(sz);
    for (int i = 0; i < n; i++) v += longint'(ref_bytes[int'(a) + i]) << (8 * i);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [9:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] d;
    d = wd;
    for (int i = 0; i < nbytes(sz); i++) ref_bytes[int'(a) + i] = d[8*i +: 8];
  endtask

  // One request: wait for ready, drive at a falling edge, then watch every
  // cycle until the response pulse. Returns on the falling edge of the
  // response cycle, so the next call can issue back-to-back.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [9:0] a, input logic [31:0] wd);
    int waited, cyc, nrd, nwr, exp_k, exp_rd_cnt, exp_wr_cnt;
    bit bad;
    logic [31:0] exp_rd, exp_wdata;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.req_ready !== 1'b1) begin
      check({tag, "_ready_timeout"}, 32'(bus.req_ready), 32'd1);
      return;
    end
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;

    bad = ref_bad(sz, a);
    exp_rd = 32'h0;
    exp_wdata = 32'h0;
    if (bad) begin
      exp_k = 1; exp_rd_cnt = 0; exp_wr_cnt = 0;
    end else if (w) begin
      ref_store(a, sz, wd);
      exp_wdata = ref_word(int'(a));
      exp_k = (sz == 2'd2) ? 1 : 3;
      exp_rd_cnt = (sz == 2'd2) ? 0 : 1;
      exp_wr_cnt = 1;
    end else begin
      exp_rd = ref_load(a, sz, sg);
      exp_k = 2; exp_rd_cnt = 1; exp_wr_cnt = 0;
    end

    @(posedge clk);
    cyc = 0; nrd = 0; nwr = 0;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;
        bus.req_addr  = 10'($urandom);
      end
      if (bus.mem_memRead === 1'b1 && bus.mem_memWrite === 1'b1)
        check({tag, "_strobe_excl"}, 32'd1, 32'd0);
      if (bus.mem_memRead === 1'b1) begin
        nrd++;
        check({tag, "_rd_addr"}, 32'(bus.mem_address), 32'(a[9:2]));
      end
      if (bus.mem_memWrite === 1'b1) begin
        nwr++;
        check({tag, "_wr_addr"}, 32'(bus.mem_address), 32'(a[9:2]));
        check({tag, "_wr_data"}, bus.mem_inData, exp_wdata);
      end
      if (bus.resp_valid === 1'b1) break;
    end
    check({tag, "_latency"}, 32'(cyc - 1), 32'(exp_k));
    check({tag, "_rdata"}, bus.resp_rdata, exp_rd);
    check({tag, "_error"}, 32'(bus.resp_error), 32'(bad));
    check({tag, "_rd_cnt"}, 32'(nrd), 32'(exp_rd_cnt));
    check({tag, "_wr_cnt"}, 32'(nwr), 32'(exp_wr_cnt));
    check({tag, "_ready_at_resp"}, 32'(bus.req_ready), 32'd1);
    $display("txn %-12s w=%0d size=%0d sgn=%0d addr=%03h wdata=%08h -> rdata=%08h err=%0d k=%0d",
             tag, w, sz, sg, a, wd, bus.resp_rdata, bus.resp_error, cyc - 1);
  endtask

  task automatic check_mem_image(input string tag);
    int bad_words;
    bad_words = 0;
    for (int i = 0; i < 256; i++)
      if (mem_array[i] !== ref_word(4 * i)) bad_words++;
    check(tag, 32'(bad_words), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0] sz;
    logic [9:0] a;
    logic [31:0] wd;

    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      mem_array[i] = r;
      for (int j = 0; j < 4; j++) ref_bytes[4*i + j] = r[8*j +: 8];
    end
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = 32'h0;

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready",   32'(bus.req_ready), 32'd1);
    check("rst_resp_valid",  32'(bus.resp_valid), 32'd0);
    check("rst_resp_error",  32'(bus.resp_error), 32'd0);
    check("rst_resp_rdata",  bus.resp_rdata, 32'h0);
    check("rst_mem_read",    32'(bus.mem_memRead), 32'd0);
    check("rst_mem_write",   32'(bus.mem_memWrite), 32'd0);
    check("rst_mem_address", 32'(bus.mem_address), 32'd0);
    check("rst_mem_indata",  bus.mem_inData, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store then word load.
    do_req("st_word", 1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF);
    do_req("ld_word", 1'b0, 2'd2, 1'b0, 10'h010, 32'h0);

    // Byte store (read-modify-write) over a known word.
    do_req("st_base", 1'b1, 2'd2, 1'b0, 10'h010, 32'h11223344);
    do_req("st_byte", 1'b1, 2'd0, 1'b0, 10'h013, 32'hFFFFFF5A);
    check("rmw_word4", mem_array[4], 32'h5A223344);

    // Sign/zero extension.
    do_req("ld_sbyte", 1'b0, 2'd0, 1'b1, 10'h013, 32'h0);
    check("ld_sbyte_val", bus.resp_rdata, 32'h0000005A);
    do_req("st_neg", 1'b1, 2'd2, 1'b0, 10'h010, 32'h80011234);
    do_req("ld_shalf", 1'b0, 2'd1, 1'b1, 10'h012, 32'h0);
    check("ld_shalf_val", bus.resp_rdata, 32'hFFFF8001);
    do_req("ld_uhalf", 1'b0, 2'd1, 1'b0, 10'h012, 32'h0);
    check("ld_uhalf_val", bus.resp_rdata, 32'h00008001);

    // Alignment errors.
    do_req("err_half", 1'b0, 2'd1, 1'b0, 10'h011, 32'h0);
    do_req("err_word", 1'b1, 2'd2, 1'b0, 10'h012, 32'hCAFEF00D);
    do_req("err_size", 1'b0, 2'd3, 1'b0, 10'h010, 32'h0);

    // Back-to-back word stores with req_valid held high.
    for (int i = 0; i < 4; i++) begin
      check("b2b_ready", 32'(bus.req_ready), 32'd1);
      if (i > 0) check("b2b_resp", 32'(bus.resp_valid), 32'd1);
      a  = 10'h040 + 10'(4 * i);
      wd = $urandom;
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_size   = 2'd2;
      bus.req_signed = 1'b0;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      ref_store(a, 2'd2, wd);
      @(posedge clk);
      @(negedge clk);
      check("b2b_busy",   32'(bus.req_ready), 32'd0);
      check("b2b_write",  32'(bus.mem_memWrite), 32'd1);
      check("b2b_noread", 32'(bus.mem_memRead), 32'd0);
      check("b2b_addr",   32'(bus.mem_address), 32'(a[9:2]));
      check("b2b_data",   bus.mem_inData, wd);
      $display("txn b2b_store    addr=%03h wdata=%08h", a, wd);
      @(negedge clk);
    end
    check("b2b_last_resp", 32'(bus.resp_valid), 32'd1);
    bus.req_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of RD of a byte store: no clock edge needed to
    // drop the strobe, and memory must be left untouched.
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'd0;
    bus.req_addr   = 10'h021;
    bus.req_wdata  = 32'h000000A5;
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    check("midrd_read_hi", 32'(bus.mem_memRead), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrd_read_lo",  32'(bus.mem_memRead), 32'd0);
    check("midrd_resp",     32'(bus.resp_valid), 32'd0);
    check("midrd_write_lo", 32'(bus.mem_memWrite), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrd_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    check("midrd_ready", 32'(bus.req_ready), 32'd1);
    check("midrd_mem_untouched", mem_array[8], ref_word(10'h020));
    $display("txn reset_mid_rd addr=021 aborted");

    // Randomized traffic against the byte-level reference.
    for (int n = 0; n < 150; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 10'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_req("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    check_mem_image("mem_image");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
